fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Program-counter / fetch sequencer; drives the 8-bit PC into the combinational instruction ROM.
//  Consumes the returned 9-bit instruction.
//  Runs one program from a selectable entry point (e.g. 0 = A*B*C, 28 = string match).
//  Resolves branches through a 16-entry absolute-target LUT, stops on the all-zero "done" word
//  and reports Done plus a cycle count to the testbench/top level.
// PARAMETERS
//  PC_W     8    PC / branch-target width
//  I_W      9    instruction width
//  CNT_W    16   cycle-counter width
// PORTS
//  Clk        in   1      clock, all state updates on posedge
//  Reset      in   1      synchronous, active-high; overrides every other input
//  Start      in   1      level; sampled in IDLE/HALT to launch a program
//  StartAddr  in   PC_W   entry PC loaded when Start is accepted
//  Instr      in   I_W    instruction word for current PC (same cycle, from ROM)
//  Stall      in   1      hold PC this cycle (downstream not ready)
//  BrEn       in   1      current instruction is a branch
//  BrCond     in   2      00 always, 01 eq (FlagZ), 10 lt (FlagLT), 11 gt (FlagGT)
//  BrIdx      in   4      index into target LUT
//  FlagZ      in   1      compare-equal flag from ALU
//  FlagLT     in   1      compare-less flag
//  FlagGT     in   1      compare-greater flag
//  PC         out  PC_W   current fetch address (registered)
//  Fetching   out  1      PC/Instr pair is live this cycle (state RUN)
//  Done       out  1      program halted (state HALT)
//  CycleCnt   out  CNT_W  cycles spent in RUN, including stalls
//  Err        out  1      sticky: PC wrapped 255->0 during RUN
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, Fetching=0, Done=0, CycleCnt=0, Err=0. Reset mid-run behaves identically.
//  States (registered, 3-state FSM):
//  - IDLE: Start=1 -> RUN, PC<=StartAddr, CycleCnt<=0, Err<=0.
//  - RUN: CycleCnt +1 every cycle, saturating at all-ones. Per-cycle priority, highest first:
//    - Stall=1 -> PC held; halt and branch are not evaluated.
//    - Instr==0 -> HALT, PC held at the done address.
//    - branch taken (BrEn & cond true) -> PC<=LUT[BrIdx].
//    - otherwise PC<=PC+1, modulo 2^PC_W. 255->0 sets Err; no stop.
//    - Start is ignored in RUN.
//  - HALT: Done=1, PC/CycleCnt/Err frozen. Start=1 -> RUN exactly as from IDLE (restart).
//  Latency:
//  - PC changes 1 cycle after the deciding Instr.
//  - Done rises 1 cycle after the all-zero word is presented.
//  - Fetching=1 on the first cycle after Start is accepted.
//  Outputs are decoded from state/registers only; no combinational path from inputs to outputs.
//  Branch cond "true" uses flags as presented that cycle. BrEn with Instr==0 -> halt wins.
//  Unused LUT entries return 0.
// STRUCTURE
//  fetch_pkg:
//  - state_t {IDLE,RUN,HALT}.
//  - brcond_t {BR_AL,BR_EQ,BR_LT,BR_GT}.
//  - localparam HALT_WORD = 9'b0.
//  - target constants: 0 loop=2, 1 shift=8, 2 lowerloop=23, 3 stringLoop=28, 4 matchLoop=32,
//    5 found=42, 6 incJ=43.
//  Sub-module branch_lut: combinational 4-bit idx -> PC_W target, table from fetch_pkg.
//  Top holds FSM, PC register, condition mux, saturating counter, Err flag.
// TESTING
//  1. Reset held 2 cycles -> PC=0, Done=0, Fetching=0, CycleCnt=0, Err=0.
//  2. ROM stub, Start, StartAddr=0, no branches
//     -> PC 0,1,..,27; Instr=0 at 27 -> next cycle Done=1, PC=27, CycleCnt=28.
//  3. At PC=4: BrEn, BrCond=01, BrIdx=1, FlagZ=1 -> PC=8 next; repeat with FlagZ=0 -> PC=5.
//  4. At PC=10: Stall 3 cycles -> PC stays 10, CycleCnt +3; then PC=11.
//  5. StartAddr=250, ROM never 0 -> PC 255 then 0, Err=1.
//     Err stays 1 until next accepted Start or Reset.
//  6. Start pulse during RUN at PC=30 -> ignored.
//     Reset at PC=35 -> IDLE, PC=0 next cycle.
//     Then Start, StartAddr=28 -> PC=28, Fetching=1.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and branch-target constants for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    typedef enum logic [1:0] {BR_AL, BR_EQ, BR_LT, BR_GT} brcond_t;

    localparam logic [8:0] HALT_WORD = 9'b0;

    localparam logic [7:0] TGT_LOOP       = 8'd2;
    localparam logic [7:0] TGT_SHIFT      = 8'd8;
    localparam logic [7:0] TGT_LOWERLOOP  = 8'd23;
    localparam logic [7:0] TGT_STRINGLOOP = 8'd28;
    localparam logic [7:0] TGT_MATCHLOOP  = 8'd32;
    localparam logic [7:0] TGT_FOUND      = 8'd42;
    localparam logic [7:0] TGT_INCJ       = 8'd43;

    function automatic logic [7:0] lut_target(input logic [3:0] idx);
        logic [7:0] tgt;
        tgt = '0;
        case (idx)
            4'd0:    tgt = TGT_LOOP;
            4'd1:    tgt = TGT_SHIFT;
            4'd2:    tgt = TGT_LOWERLOOP;
            4'd3:    tgt = TGT_STRINGLOOP;
            4'd4:    tgt = TGT_MATCHLOOP;
            4'd5:    tgt = TGT_FOUND;
            4'd6:    tgt = TGT_INCJ;
            default: tgt = '0;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: launch control, ROM word, branch/flag inputs and status outputs.
interface fetch_ctrl_if #(
    parameter int PC_W  = 8,
    parameter int I_W   = 9,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic [I_W-1:0]   Instr;
    logic             Stall;
    logic             BrEn;
    logic [1:0]       BrCond;
    logic [3:0]       BrIdx;
    logic             FlagZ;
    logic             FlagLT;
    logic             FlagGT;
    logic [PC_W-1:0]  PC;
    logic             Fetching;
    logic             Done;
    logic [CNT_W-1:0] CycleCnt;
    logic             Err;

    modport master (
        output Start, StartAddr, Instr, Stall, BrEn, BrCond, BrIdx, FlagZ, FlagLT, FlagGT,
        input  PC, Fetching, Done, CycleCnt, Err
    );

    modport slave (
        input  Start, StartAddr, Instr, Stall, BrEn, BrCond, BrIdx, FlagZ, FlagLT, FlagGT,
        output PC, Fetching, Done, CycleCnt, Err
    );
endinterface

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-target table; unused indices return 0.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [3:0]      idx_i,
    output logic [PC_W-1:0] tgt_o
);
    assign tgt_o = PC_W'(lut_target(idx_i));
endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter / fetch sequencer: IDLE/RUN/HALT FSM, branch resolution, cycle counter, wrap flag.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int I_W   = 9,
    parameter int CNT_W = 16
) (
    input logic         Clk,
    input logic         Reset,
    fetch_ctrl_if.slave bus
);
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [PC_W-1:0]   lut_tgt;
    logic              cond_true;
    brcond_t           cond;

    branch_lut #(.PC_W(PC_W)) u_lut (
        .idx_i (bus.BrIdx),
        .tgt_o (lut_tgt)
    );

    assign cond = brcond_t'(bus.BrCond);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            BR_AL:   cond_true = 1'b1;
            BR_EQ:   cond_true = bus.FlagZ;
            BR_LT:   cond_true = bus.FlagLT;
            BR_GT:   cond_true = bus.FlagGT;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
                // Stall masks both halt and branch; halt outranks a branch on the done word
                if (!bus.Stall) begin
                    if (bus.Instr == I_W'(HALT_WORD)) begin
                        state_d = HALT;
                    end else if (bus.BrEn && cond_true) begin
                        pc_d = lut_tgt;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                        if (pc_q == '1)
                            err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.Fetching = (state_q == RUN);
    assign bus.Done     = (state_q == HALT);
    assign bus.CycleCnt = cnt_q;
    assign bus.Err      = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a ROM stub that returns the done word at a chosen PC.
module tb_fetch_ctrl;
    logic Clk;
    logic Reset;
    logic       rom_halt_en;
    logic [7:0] halt_pc;
    int n_vec;
    int n_err;

    fetch_ctrl_if #(.PC_W(8), .I_W(9), .CNT_W(16)) bus ();

    fetch_ctrl #(.PC_W(8), .I_W(9), .CNT_W(16)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.Instr = (rom_halt_en && bus.PC == halt_pc) ? 9'h000 : 9'h1A5;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic set_br(input logic en, input logic [1:0] c, input logic [3:0] idx,
                          input logic z, input logic lt, input logic gt);
        bus.BrEn   = en;
        bus.BrCond = c;
        bus.BrIdx  = idx;
        bus.FlagZ  = z;
        bus.FlagLT = lt;
        bus.FlagGT = gt;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b1;
        rom_halt_en = 1'b1;
        halt_pc = 8'd27;
        bus.Start = 1'b0;
        bus.StartAddr = '0;
        bus.Stall = 1'b0;
        set_br(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick(2);
        chk("rst_pc", bus.PC, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_fetch", bus.Fetching, 0);
        chk("rst_cnt", bus.CycleCnt, 0);
        chk("rst_err", bus.Err, 0);
        Reset = 1'b0;
        tick();
        chk("idle_pc", bus.PC, 0);
        chk("idle_fetch", bus.Fetching, 0);

        // Straight-line run to the done word at 27
        bus.Start = 1'b1;
        bus.StartAddr = 8'd0;
        tick();
        bus.Start = 1'b0;
        chk("run_pc0", bus.PC, 0);
        chk("run_fetch", bus.Fetching, 1);
        tick(13);
        chk("run_pc13", bus.PC, 13);
        tick(14);
        chk("run_pc27", bus.PC, 27);
        chk("run_done0", bus.Done, 0);
        tick();
        chk("halt_done", bus.Done, 1);
        chk("halt_pc", bus.PC, 27);
        chk("halt_cnt", bus.CycleCnt, 28);
        chk("halt_fetch", bus.Fetching, 0);
        tick();
        chk("halt_frz_pc", bus.PC, 27);
        chk("halt_frz_cnt", bus.CycleCnt, 28);

        // Branches, restarted from HALT
        bus.Start = 1'b1;
        bus.StartAddr = 8'd0;
        tick();
        bus.Start = 1'b0;
        chk("rst_restart_pc", bus.PC, 0);
        chk("restart_done", bus.Done, 0);
        tick(4);
        chk("br_pre_pc4", bus.PC, 4);
        set_br(1'b1, 2'b01, 4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("br_eq_taken", bus.PC, 8);
        set_br(1'b1, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("br_al_loop", bus.PC, 2);
        set_br(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(2);
        set_br(1'b1, 2'b01, 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("br_eq_nottaken", bus.PC, 5);
        set_br(1'b1, 2'b10, 4'd5, 1'b0, 1'b1, 1'b0);
        tick();
        chk("br_lt_found", bus.PC, 42);
        set_br(1'b1, 2'b11, 4'd6, 1'b0, 1'b1, 1'b0);
        tick();
        chk("br_gt_nottaken", bus.PC, 43);
        set_br(1'b1, 2'b11, 4'd15, 1'b0, 1'b0, 1'b1);
        tick();
        chk("br_unused_idx", bus.PC, 0);
        chk("br_cnt", bus.CycleCnt, 12);
        set_br(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Stall holds PC and masks a pending branch
        tick(10);
        chk("stall_pre_pc", bus.PC, 10);
        bus.Stall = 1'b1;
        set_br(1'b1, 2'b00, 4'd3, 1'b0, 1'b0, 1'b0);
        tick(3);
        chk("stall_pc", bus.PC, 10);
        chk("stall_cnt", bus.CycleCnt, 25);
        bus.Stall = 1'b0;
        set_br(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall_rel_pc", bus.PC, 11);

        // Done word beats a taken branch
        halt_pc = 8'd11;
        set_br(1'b1, 2'b00, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        set_br(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("halt_vs_br_done", bus.Done, 1);
        chk("halt_vs_br_pc", bus.PC, 11);
        chk("halt_vs_br_cnt", bus.CycleCnt, 27);

        // PC wrap sets sticky Err
        rom_halt_en = 1'b0;
        bus.Start = 1'b1;
        bus.StartAddr = 8'd250;
        tick();
        bus.Start = 1'b0;
        chk("wrap_start_pc", bus.PC, 250);
        tick(5);
        chk("wrap_pc255", bus.PC, 255);
        chk("wrap_err0", bus.Err, 0);
        tick();
        chk("wrap_pc0", bus.PC, 0);
        chk("wrap_err1", bus.Err, 1);
        tick();
        halt_pc = 8'd2;
        rom_halt_en = 1'b1;
        tick(2);
        chk("wrap_halt_done", bus.Done, 1);
        chk("wrap_halt_cnt", bus.CycleCnt, 9);
        tick();
        chk("wrap_halt_err", bus.Err, 1);

        // Restart clears Err; Start ignored in RUN; reset mid-run
        rom_halt_en = 1'b0;
        bus.Start = 1'b1;
        bus.StartAddr = 8'd28;
        tick();
        bus.Start = 1'b0;
        chk("str_pc", bus.PC, 28);
        chk("str_fetch", bus.Fetching, 1);
        chk("str_err", bus.Err, 0);
        tick(2);
        bus.Start = 1'b1;
        bus.StartAddr = 8'd0;
        tick();
        bus.Start = 1'b0;
        chk("run_start_ign", bus.PC, 31);
        tick(4);
        chk("pre_rst_pc", bus.PC, 35);
        chk("pre_rst_cnt", bus.CycleCnt, 7);
        Reset = 1'b1;
        bus.Start = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_pc", bus.PC, 0);
        chk("midrst_fetch", bus.Fetching, 0);
        chk("midrst_cnt", bus.CycleCnt, 0);
        bus.StartAddr = 8'd28;
        tick();
        bus.Start = 1'b0;
        chk("post_rst_pc", bus.PC, 28);
        chk("post_rst_fetch", bus.Fetching, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
